// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and prescaler divisor helper
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    // Rounded clock cycles per oversample tick, never below one.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        longint d;
        longint q;
        d = longint'(baud) * longint'(oversample);
        q = (longint'(clk_hz) + d / 2) / d;
        if (q < 1) begin
            q = 1;
        end
        return int'(q);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - prescaler emitting a one-cycle tick every DIV cycles
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Held phase restart suppresses ticks, so the first tick lands DIV cycles after release.
    assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 receiver with valid/ready holding register
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 54_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    rx_state_e                  state;
    logic                       sync1, rxs, rxs_d;
    logic                       tick, decide, maj;
    logic [TW-1:0]              tick_cnt, tick_nxt;
    logic [2:0]                 bit_idx;
    logic [1:0]                 samp;
    logic [UART_DATA_BITS-1:0]  shift;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .restart (state == IDLE),
        .tick    (tick)
    );

    assign tick_nxt = (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
    assign decide   = tick && (tick_cnt == T_S2);
    assign maj      = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
    assign busy     = (state != IDLE);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            samp      <= '0;
            shift     <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (tick && tick_cnt == T_S0) samp[0] <= rxs;
            if (tick && tick_cnt == T_S1) samp[1] <= rxs;

            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (rxs_d && !rxs) state <= START;
                end
                START: if (tick) begin
                    tick_cnt <= tick_nxt;
                    if (decide && maj) begin
                        state <= IDLE;
                    end else if (tick_cnt == T_LAST) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: if (tick) begin
                    tick_cnt <= tick_nxt;
                    if (decide) shift <= {maj, shift[UART_DATA_BITS-1:1]};
                    if (tick_cnt == T_LAST) begin
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) state <= STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP: if (tick) begin
                    tick_cnt <= tick_nxt;
                    if (decide) begin
                        if (maj) begin
                            state <= IDLE;
                            // A same-cycle handshake frees the register for the new byte.
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                            tick_cnt  <= '0;
                        end
                    end
                end
                BREAK: begin
                    if (!rxs) begin
                        tick_cnt <= '0;
                    end else if (tick) begin
                        tick_cnt <= tick_nxt;
                        if (tick_cnt == T_LAST) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a byte-level reference queue
module tb_uart_rx;

    localparam int DIV = 4;
    localparam int OS  = 16;
    localparam int CPB = DIV * OS;
    // Cycle index (counted from the start-bit edge) in which the stop-bit decision is taken.
    localparam int DONE_CYC = 3 + DIV * (9 * OS + OS / 2 + 2) - 1;

    logic       sys_clk;
    logic       reset_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         passed = 0;
    int         total = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         vld_rise = 0;
    logic       vld_d = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         gi = 0;

    uart_rx #(
        .CLK_HZ     (1_600_000),
        .BAUD       (25_000),
        .OVERSAMPLE (16)
    ) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (reset_n) begin
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid && !vld_d) vld_rise++;
        end
        vld_d <= rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] e);
        check(tag, (got.size() > gi) ? 32'(got[gi]) : 32'hDEAD, 32'(e));
        gi++;
    endtask

    // rdy_at >= 0 drives rx_ready high only in that cycle; rst_at >= 0 resets mid-frame.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int cpb,
                              input int rdy_at, input int rst_at);
        logic bitv;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) bitv = 1'b0;
            else if (i == 9) bitv = stop;
            else bitv = b[i-1];
            for (int c = 0; c < cpb; c++) begin
                rxd = bitv;
                if (rdy_at >= 0) rx_ready = (i * cpb + c == rdy_at);
                if (i * cpb + c == rst_at) begin
                    reset_n = 1'b0;
                    #1;
                    check("rst_mid_valid", rx_valid, 0);
                    check("rst_mid_data", rx_data, 0);
                    check("rst_mid_busy", busy, 0);
                    check("rst_mid_ferr", frame_err, 0);
                    check("rst_mid_ovr", overrun, 0);
                end
                @(posedge sys_clk);
                #1;
            end
        end
        if (rdy_at >= 0) rx_ready = 1'b0;
        if (rst_at >= 0) reset_n = 1'b1;
    endtask

    initial begin
        int fe0;
        int ov0;
        int g0;
        logic [7:0] b;

        reset_n  = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        wait_cyc(5);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_busy", busy, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);
        reset_n = 1'b1;
        wait_cyc(20);

        send_frame(8'hA5, 1'b1, CPB, -1, -1);
        wait_cyc(10);
        expect_byte("a5_data", 8'hA5);
        check("a5_ferr", fe_cnt, 0);
        check("a5_ovr", ov_cnt, 0);
        check("a5_pulses", vld_rise, 1);

        // Two-bit low reads as start plus a zero LSB, the rest idle-high ones.
        rxd = 1'b0;
        wait_cyc(2 * CPB);
        rxd = 1'b1;
        wait_cyc(10 * CPB);
        expect_byte("long_low", 8'hFE);
        g0 = got.size();
        rxd = 1'b0;
        wait_cyc(CPB / 4);
        rxd = 1'b1;
        wait_cyc(4);
        check("glitch_busy_hi", busy, 1);
        wait_cyc(CPB - CPB / 4 - 4);
        check("glitch_busy_lo", busy, 0);
        wait_cyc(10 * CPB);
        check("glitch_nobyte", got.size(), g0);

        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, CPB, -1, -1);
        rxd = 1'b0;
        wait_cyc(20 * CPB);
        rxd = 1'b1;
        wait_cyc(2 * CPB);
        check("break_ferr", fe_cnt - fe0, 1);
        check("break_nobyte", got.size(), g0);
        send_frame(8'h81, 1'b1, CPB, -1, -1);
        wait_cyc(10);
        expect_byte("after_break", 8'h81);

        rx_ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, CPB, -1, -1);
        send_frame(8'h22, 1'b1, CPB, -1, -1);
        wait_cyc(10);
        check("ovr_valid", rx_valid, 1);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_pulse", ov_cnt - ov0, 1);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        check("ovr_drain", rx_valid, 0);
        expect_byte("ovr_byte", 8'h11);

        ov0 = ov_cnt;
        send_frame(8'h55, 1'b1, CPB, -1, -1);
        wait_cyc(10);
        check("pend_valid", rx_valid, 1);
        check("pend_data", rx_data, 8'h55);
        send_frame(8'hAA, 1'b1, CPB, DONE_CYC, -1);
        wait_cyc(10);
        check("swap_valid", rx_valid, 1);
        check("swap_data", rx_data, 8'hAA);
        check("swap_noovr", ov_cnt - ov0, 0);
        expect_byte("swap_old", 8'h55);
        rx_ready = 1'b1;
        wait_cyc(2);
        expect_byte("swap_new", 8'hAA);

        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, CPB, -1, -1);
        wait_cyc(10);
        check("pre_rst_valid", rx_valid, 1);
        send_frame(8'hC3, 1'b1, CPB, -1, 5 * CPB + 30);
        rx_ready = 1'b1;
        wait_cyc(10);
        send_frame(8'h0F, 1'b1, CPB, -1, -1);
        wait_cyc(10);
        expect_byte("post_rst", 8'h0F);

        send_frame(8'hA5, 1'b1, CPB - CPB * 3 / 100, -1, -1);
        wait_cyc(10);
        expect_byte("fast_a5", 8'hA5);
        send_frame(8'hA5, 1'b1, CPB + CPB * 3 / 100, -1, -1);
        wait_cyc(10);
        expect_byte("slow_a5", 8'hA5);

        repeat (6) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1, $urandom_range(CPB - 2, CPB + 2), -1, -1);
            wait_cyc($urandom_range(0, 40));
        end
        wait_cyc(10);
        while (exp_q.size() > 0) expect_byte("rand", exp_q.pop_front());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Fabric-side 8N1 UART receiver that terminates the serial stream transmitted by the on-chip MCU's UART TX pin, giving FPGA logic a byte-wide command channel from firmware. It oversamples the line, validates the start and stop bits, and presents each received byte through a valid/ready holding register. Framing and overrun conditions are flagged as single-cycle pulses. It runs in the 54 MHz PLL clock domain alongside the MCU.

## Interface
- CLK_HZ, 54_000_000: frequency of sys_clk in Hz.
- BAUD, 115_200: line rate in bit/s.
- OVERSAMPLE, 16: ticks per bit; even, ≥ 8.
- sys_clk  in  1  the single clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rxd  in  1  serial line, idle high; asynchronous to sys_clk.
- rx_data  out  8  received byte; stable while rx_valid is high.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a byte completed while the holding register was full and not being drained.
- busy  out  1  high in any state other than IDLE.

## Operation
- Input path: two-flop synchronizer on rxd; both flops reset to 1.
- Tick generator: DIV = round(CLK_HZ / (BAUD·OVERSAMPLE)), minimum 1. One-cycle tick every DIV cycles. Phase is reset on entry to START.
- Tick counter counts 0..OVERSAMPLE-1 within each bit. Bit value is the majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1, and is decided on the last of those three ticks.
- FSM states and transitions:
  - IDLE -> START on a synchronized falling edge of rxd.
  - START: if the majority value is 1 (false start) -> IDLE. If 0 -> DATA at tick OVERSAMPLE-1.
  - DATA: 8 bits, LSB first, shifted into a shift register. After bit 7 -> STOP.
  - STOP, majority 1: byte completes; go to IDLE immediately after the decision (no wait for end of bit).
  - STOP, majority 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK -> IDLE once the synchronized rxd has been high for one full bit time (OVERSAMPLE ticks). A held-low break yields exactly one frame_err.
- Holding register:
  - On completion with rx_valid=0: load rx_data, set rx_valid.
  - With rx_valid=1 and rx_ready=1 in the same cycle: load the new byte, rx_valid stays 1, no overrun.
  - With rx_valid=1 and rx_ready=0: pulse overrun, drop the new byte, old byte retained.
  - Handshake with no completion: rx_valid clears the next cycle.
- rx_valid never drops without a handshake. rx_data changes only on load.
- Reset (any time, including mid-frame): state IDLE, counters 0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0. A partially received frame is lost. The receiver does not resync on a stale low line: a new frame needs a fresh falling edge after reset.

## Timing
- Sync latency: 2 cycles from rxd pin to the FSM.
- rx_valid/rx_data, frame_err and overrun are registered. They assert 1 cycle after the stop-bit decision tick, i.e. ≈ 9.5 bit times plus 3–4 cycles after the pin falling edge.
- Accepted baud error: ±3 % cumulative over 10 bits.
- Back-to-back frames: a start edge arriving ≥ half a bit after the stop-bit decision is captured with no gap.

## Structure
- Package uart_pkg:
  - rx_state_e enum (IDLE, START, DATA, STOP, BREAK).
  - UART_DATA_BITS=8.
  - A constant function computing DIV from CLK_HZ, BAUD and OVERSAMPLE.
  - Shared with a future fabric uart_tx.
- Sub-module uart_baud_tick: prescaler with a synchronous phase-restart input and a tick output. It is reused by the transmitter.

## Test plan
Bench parameters: CLK_HZ=1_600_000, BAUD=25_000, OVERSAMPLE=16. This gives DIV=4 and 64 cycles per bit.
- Single byte 8'hA5, rx_ready held 1 -> one rx_valid pulse with rx_data=8'hA5; frame_err=0, overrun=0.
- 2-bit-time-long low glitch, then a 0.25-bit glitch -> the 0.25-bit glitch gives no rx_valid and busy returns low within 1 bit. The 2-bit low is a normal start.
- Byte 8'h3C with the stop bit forced low, then line held low for 20 bits -> exactly one frame_err pulse, no rx_valid. The next valid 8'h81 after the line returns high is received.
- rx_ready=0; send 8'h11 then 8'h22 -> rx_data stays 8'h11 and one overrun pulse occurs. Asserting rx_ready then clears rx_valid.
- 8'h55 pending; assert rx_ready exactly on the completion cycle of 8'hAA -> rx_valid stays 1, rx_data=8'hAA, no overrun.
- Assert reset_n low in the middle of bit 4 of a frame -> all outputs reset at once. The following frame 8'h0F is received correctly. Also rerun the 8'hA5 case with baud at ±3 % and confirm it still decodes.
